// File: rtl/bp_pkg.sv
// Shared types and default widths for the branch-predictor update controller.
// Anything that names predictor state or update records imports this package.
package bp_pkg;

    localparam int PHT_INDEX_BITS_DEF = 7;
    localparam int BHT_INDEX_BITS_DEF = 3;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } predict_state_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic [BHT_INDEX_BITS_DEF-1:0] bht_index;
        logic [PHT_INDEX_BITS_DEF-1:0] pht_index;
        logic                          taken;
        logic                          correct;
    } upd_rec_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Update queue: DEPTH-entry FIFO with wrap-bit pointers and a synchronous flush.
// Storage is not reset; only the pointers are.
module bp_update_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Predictor update controller: clears the tables after reset or reinit, then
// drains queued resolved-branch updates to the predictor one per cycle.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int PHT_INDEX_BITS = PHT_INDEX_BITS_DEF,
    parameter int BHT_INDEX_BITS = BHT_INDEX_BITS_DEF,
    parameter int QDEPTH         = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reinit_i,
    input  logic                      hold_i,
    input  logic                      upd_valid_i,
    output logic                      upd_ready_o,
    input  logic [BHT_INDEX_BITS-1:0] upd_bht_index_i,
    input  logic [PHT_INDEX_BITS-1:0] upd_pht_index_i,
    input  logic                      upd_taken_i,
    input  logic                      upd_correct_i,
    output logic                      bp_update_o,
    output logic [BHT_INDEX_BITS-1:0] bp_bht_index_o,
    output logic [PHT_INDEX_BITS-1:0] bp_pht_index_o,
    output logic                      bp_taken_o,
    output logic                      bp_correct_o,
    output logic                      bp_init_o,
    output logic [PHT_INDEX_BITS-1:0] bp_init_index_o,
    output logic                      predict_valid_o
);

    localparam int REC_W = BHT_INDEX_BITS + PHT_INDEX_BITS + 2;
    localparam logic [PHT_INDEX_BITS-1:0] LAST_IDX = '1;

    ctrl_state_t               r_state;
    ctrl_state_t               w_next_state;
    logic [PHT_INDEX_BITS-1:0] r_init_idx;
    logic                      w_run;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [REC_W-1:0]          w_wdata;
    logic [REC_W-1:0]          w_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            INIT: if (!reinit_i && r_init_idx == LAST_IDX) w_next_state = RUN;
            RUN:  if (reinit_i) w_next_state = INIT;
            default: w_next_state = INIT;
        endcase
    end

    // Outputs are gated by rst so every strobe is low while reset is held.
    always_comb begin
        w_run           = (r_state == RUN) && rst;
        bp_init_o       = (r_state == INIT) && rst;
        bp_init_index_o = bp_init_o ? r_init_idx : '0;
        predict_valid_o = w_run;
        upd_ready_o     = w_run && !w_full;
        w_pop           = w_run && !w_empty && !hold_i && !reinit_i;
    end

    always_ff @(posedge clk) begin
        if (!rst || reinit_i || r_state != INIT) begin
            r_init_idx <= '0;
        end else begin
            r_init_idx <= r_init_idx + 1'b1;
        end
    end

    assign w_push  = upd_valid_i && upd_ready_o;
    assign w_wdata = {upd_bht_index_i, upd_pht_index_i, upd_taken_i, upd_correct_i};

    bp_update_fifo #(
        .WIDTH (REC_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (reinit_i),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    assign bp_update_o = w_pop;
    assign {bp_bht_index_o, bp_pht_index_o, bp_taken_o, bp_correct_o} =
        w_pop ? w_rdata : '0;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed and randomized bench for bp_update_ctrl against a queue-based model.
module tb_bp_update_ctrl;

    localparam int PB = 7;
    localparam int BB = 3;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          reinit_i;
    logic          hold_i;
    logic          upd_valid_i;
    logic          upd_ready_o;
    logic [BB-1:0] upd_bht_index_i;
    logic [PB-1:0] upd_pht_index_i;
    logic          upd_taken_i;
    logic          upd_correct_i;
    logic          bp_update_o;
    logic [BB-1:0] bp_bht_index_o;
    logic [PB-1:0] bp_pht_index_o;
    logic          bp_taken_o;
    logic          bp_correct_o;
    logic          bp_init_o;
    logic [PB-1:0] bp_init_index_o;
    logic          predict_valid_o;

    always #5 clk = ~clk;

    bp_update_ctrl #(
        .PHT_INDEX_BITS (PB),
        .BHT_INDEX_BITS (BB),
        .QDEPTH         (QD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .reinit_i        (reinit_i),
        .hold_i          (hold_i),
        .upd_valid_i     (upd_valid_i),
        .upd_ready_o     (upd_ready_o),
        .upd_bht_index_i (upd_bht_index_i),
        .upd_pht_index_i (upd_pht_index_i),
        .upd_taken_i     (upd_taken_i),
        .upd_correct_i   (upd_correct_i),
        .bp_update_o     (bp_update_o),
        .bp_bht_index_o  (bp_bht_index_o),
        .bp_pht_index_o  (bp_pht_index_o),
        .bp_taken_o      (bp_taken_o),
        .bp_correct_o    (bp_correct_o),
        .bp_init_o       (bp_init_o),
        .bp_init_index_o (bp_init_index_o),
        .predict_valid_o (predict_valid_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: clearing phase with a sweep position, then an ordered list of pending updates.
    bit                     m_clearing;
    int                     m_idx;
    logic [BB+PB+1:0]       m_q[$];
    int                     n_issued = 0;

    task automatic step(input string tag, input logic r, input logic rein, input logic hold,
                        input logic v, input logic [BB-1:0] b, input logic [PB-1:0] p,
                        input logic t, input logic c);
        logic [BB+PB+13:0] exp_v;
        logic [BB+PB+13:0] obs_v;
        logic              e_ready;
        logic              e_pop;
        logic [BB+PB+1:0]  head;
        logic [PB-1:0]     e_idx;
        rst = r; reinit_i = rein; hold_i = hold; upd_valid_i = v;
        upd_bht_index_i = b; upd_pht_index_i = p; upd_taken_i = t; upd_correct_i = c;
        @(negedge clk);
        exp_v = '0; e_ready = 1'b0; e_pop = 1'b0; head = '0;
        e_idx = PB'(m_idx);
        if (r) begin
            if (m_clearing) begin
                exp_v = {2'b00, {(BB+PB+2){1'b0}}, 1'b1, e_idx, 1'b0};
            end else begin
                e_ready = (m_q.size() < QD);
                e_pop   = (m_q.size() > 0) && !hold && !rein;
                if (e_pop) head = m_q[0];
                exp_v = {e_ready, e_pop, head, 1'b0, {PB{1'b0}}, 1'b1};
            end
        end
        obs_v = {upd_ready_o, bp_update_o, bp_bht_index_o, bp_pht_index_o, bp_taken_o,
                 bp_correct_o, bp_init_o, bp_init_index_o, predict_valid_o};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
        end
        if (!r) begin
            m_clearing = 1'b1; m_idx = 0; m_q.delete();
        end else if (m_clearing) begin
            if (rein) m_idx = 0;
            else if (m_idx == (1 << PB) - 1) begin m_clearing = 1'b0; m_idx = 0; end
            else m_idx++;
        end else if (rein) begin
            m_q.delete(); m_clearing = 1'b1; m_idx = 0;
        end else begin
            if (e_pop) begin void'(m_q.pop_front()); n_issued++; end
            if (v && e_ready) m_q.push_back({b, p, t, c});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, BB'($urandom), PB'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic push(input string tag, input logic hold);
        step(tag, 1'b1, 1'b0, hold, 1'b1, BB'($urandom), PB'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        m_clearing = 1'b1; m_idx = 0;
        rst = 1'b0; reinit_i = 1'b0; hold_i = 1'b0; upd_valid_i = 1'b0;
        upd_bht_index_i = '0; upd_pht_index_i = '0; upd_taken_i = 1'b0; upd_correct_i = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, '1, '1, 1'b1, 1'b1);

        // Full clear sweep after reset, with ignored update offers, then first RUN cycle.
        for (int i = 0; i < 128; i++) step($sformatf("sweep%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, BB'($urandom), PB'($urandom), 1'b1, 1'b0);
        idle("run_first");

        // Single update issues exactly one cycle later.
        step("single_push", 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 7'h2A, 1'b1, 1'b0);
        idle("single_issue");
        idle("single_after");

        // Fill under hold, fifth offer refused, then drain with overlapped push.
        for (int i = 0; i < 5; i++) push($sformatf("hold_push%0d", i), 1'b1);
        push("hold_release_pop", 1'b0);
        for (int i = 0; i < 4; i++) push($sformatf("full_pushpop%0d", i), 1'b0);
        for (int i = 0; i < 5; i++) idle($sformatf("drain%0d", i));

        // Reinit discards three queued entries.
        for (int i = 0; i < 3; i++) push($sformatf("pre_reinit%0d", i), 1'b1);
        step("reinit", 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) idle($sformatf("resweep%0d", i));

        // Reset at sweep index 60, then complete sweep from 0.
        step("rst_mid_sweep", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step("rst_hold", 1'b0, 1'b0, 1'b0, 1'b1, '1, '1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) idle($sformatf("post_rst_sweep%0d", i));
        step("reinit_in_init", 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 129; i++) idle($sformatf("sweep_b%0d", i));

        // Randomized traffic with occasional hold, reinit and reset.
        for (int i = 0; i < 600; i++) begin
            step($sformatf("rand%0d", i),
                 ($urandom % 250) != 0, ($urandom % 150) == 0, ($urandom % 4) == 0,
                 1'($urandom), BB'($urandom), PB'($urandom), 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 140; i++) idle($sformatf("tail%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
